// File: rtl/ms_wdt32_ctrl_pkg.sv
// Shared definitions for the MS_WDT32 watchdog controller: FSM states,
// reset-cause encodings, the default kick key and a small load helper.
package ms_wdt32_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_ARM  = 3'd1,
        ST_RUN  = 3'd2,
        ST_KICK = 3'd3,
        ST_BITE = 3'd4
    } wdt_state_e;

    localparam logic [1:0] CAUSE_NONE    = 2'b00;
    localparam logic [1:0] CAUSE_TIMEOUT = 2'b01;
    localparam logic [1:0] CAUSE_BADKEY  = 2'b10;
    localparam logic [1:0] CAUSE_EARLY   = 2'b11;

    localparam logic [31:0] WDT_DEFAULT_KEY = 32'h5AFE_C0DE;

    // A zero reload would make the watchdog expire instantly; treat it as 1.
    function automatic logic [31:0] clamp_load(input logic [31:0] value);
        return (value == 32'd0) ? 32'd1 : value;
    endfunction

endpackage

// File: rtl/ms_wdt32_ctrl.sv
// Control FSM for the MS_WDT32 watchdog: arms the counter, validates kicks
// against a key and a window, raises an early-warning interrupt and issues
// a fixed-width system reset pulse when the watchdog bites.
module ms_wdt32_ctrl
    import ms_wdt32_ctrl_pkg::*;
#(
    parameter logic [31:0] KEY    = WDT_DEFAULT_KEY,
    parameter int unsigned RST_PW = 16,
    parameter bit          LOCK   = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en_req,
    input  logic [31:0] cfg_load,
    input  logic [31:0] cfg_win,
    input  logic [31:0] cfg_warn,
    input  logic        kick_valid,
    input  logic [31:0] kick_key,
    input  logic        irq_clr,
    input  logic        cause_clr,
    input  logic [31:0] wdt_mr,
    input  logic        wdt_to,
    output logic [31:0] wdt_load,
    output logic        wdt_en,
    output logic        irq_warn,
    output logic        sys_rst_req,
    output logic [1:0]  rst_cause,
    output logic        running
);

    localparam logic [7:0] PULSE_W = RST_PW[7:0];

    wdt_state_e  state_q, state_d;
    logic [1:0]  bite_cause;
    logic [31:0] load_q, win_q, warn_q;
    logic [7:0]  pulse_q, pulse_d;
    logic        wdt_en_q, wdt_en_d;
    logic        running_q, running_d;
    logic        sys_rst_q, sys_rst_d;
    logic        irq_q, irq_d;
    logic [1:0]  cause_q, cause_d;
    logic        enter_arm, enter_bite;

    assign enter_arm  = (state_q != ST_ARM)  && (state_d == ST_ARM);
    assign enter_bite = (state_q != ST_BITE) && (state_d == ST_BITE);

    // State register plus all registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            pulse_q   <= 8'd0;
            wdt_en_q  <= 1'b0;
            running_q <= 1'b0;
            sys_rst_q <= 1'b0;
            irq_q     <= 1'b0;
            cause_q   <= CAUSE_NONE;
        end else begin
            state_q   <= state_d;
            pulse_q   <= pulse_d;
            wdt_en_q  <= wdt_en_d;
            running_q <= running_d;
            sys_rst_q <= sys_rst_d;
            irq_q     <= irq_d;
            cause_q   <= cause_d;
        end
    end

    // Configuration is captured on the edge entering ARM so that wdt_load is
    // already valid while wdt_en is low in ARM, letting the watchdog load it.
    always_ff @(posedge clk) begin
        if (rst) begin
            load_q <= 32'd0;
            win_q  <= 32'd0;
            warn_q <= 32'd0;
        end else if (enter_arm) begin
            load_q <= clamp_load(cfg_load);
            win_q  <= cfg_win;
            warn_q <= cfg_warn;
        end
    end

    // Next-state logic; timeout outranks any kick or enable change.
    always_comb begin
        state_d    = state_q;
        bite_cause = CAUSE_NONE;
        case (state_q)
            ST_IDLE: if (en_req) state_d = ST_ARM;
            ST_ARM:  state_d = ST_RUN;
            ST_RUN: begin
                if (wdt_to) begin
                    state_d    = ST_BITE;
                    bite_cause = CAUSE_TIMEOUT;
                end else if (kick_valid) begin
                    if (kick_key != KEY) begin
                        state_d    = ST_BITE;
                        bite_cause = CAUSE_BADKEY;
                    end else if (wdt_mr > win_q) begin
                        state_d    = ST_BITE;
                        bite_cause = CAUSE_EARLY;
                    end else begin
                        state_d = ST_KICK;
                    end
                end else if (!en_req && !LOCK) begin
                    state_d = ST_IDLE;
                end
            end
            ST_KICK: state_d = ST_RUN;
            ST_BITE: if (pulse_q <= 8'd1) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Output logic, computed from the next state so every output is a flop.
    always_comb begin
        wdt_en_d  = (state_d == ST_RUN);
        running_d = (state_d == ST_RUN) || (state_d == ST_KICK);
        sys_rst_d = (state_d == ST_BITE);

        pulse_d = pulse_q;
        if (enter_bite) begin
            pulse_d = PULSE_W;
        end else if (state_q == ST_BITE && pulse_q != 8'd0) begin
            pulse_d = pulse_q - 8'd1;
        end

        // Sticky warning: a same-cycle set beats the clear.
        irq_d = irq_q;
        if (irq_clr) irq_d = 1'b0;
        if (state_q == ST_RUN && warn_q != 32'd0 && wdt_mr == warn_q) irq_d = 1'b1;

        // Cause is recorded on BITE entry, which beats a same-cycle clear.
        cause_d = cause_q;
        if (cause_clr) cause_d = CAUSE_NONE;
        if (enter_bite) cause_d = bite_cause;
    end

    assign wdt_load    = load_q;
    assign wdt_en      = wdt_en_q;
    assign irq_warn    = irq_q;
    assign sys_rst_req = sys_rst_q;
    assign rst_cause   = cause_q;
    assign running     = running_q;

endmodule

// File: tb/tb_ms_wdt32_ctrl.sv
// Directed bench for ms_wdt32_ctrl. Two instances (LOCK=1 and LOCK=0) share
// stimulus; each drives its own small behavioural MS_WDT32 counter model.
module tb_ms_wdt32_ctrl;

    localparam logic [31:0] TB_KEY = 32'h5AFE_C0DE;

    logic        clk = 1'b0;
    logic        rst;
    logic        en_req;
    logic [31:0] cfg_load, cfg_win, cfg_warn;
    logic        kick_valid;
    logic [31:0] kick_key;
    logic        irq_clr, cause_clr;

    logic [31:0] mr_a = 32'd0, mr_b = 32'd0;
    logic        to_a, to_b;
    logic [31:0] wdt_load_a, wdt_load_b;
    logic        wdt_en_a, wdt_en_b, irq_a, irq_b, srst_a, srst_b, running_a, running_b;
    logic [1:0]  cause_a, cause_b;

    int vecs = 0;
    int errs = 0;

    always #5 clk = ~clk;

    ms_wdt32_ctrl #(.KEY(TB_KEY), .RST_PW(16), .LOCK(1'b1)) dut_a (
        .clk(clk), .rst(rst), .en_req(en_req), .cfg_load(cfg_load), .cfg_win(cfg_win),
        .cfg_warn(cfg_warn), .kick_valid(kick_valid), .kick_key(kick_key),
        .irq_clr(irq_clr), .cause_clr(cause_clr), .wdt_mr(mr_a), .wdt_to(to_a),
        .wdt_load(wdt_load_a), .wdt_en(wdt_en_a), .irq_warn(irq_a),
        .sys_rst_req(srst_a), .rst_cause(cause_a), .running(running_a)
    );

    ms_wdt32_ctrl #(.KEY(TB_KEY), .RST_PW(16), .LOCK(1'b0)) dut_b (
        .clk(clk), .rst(rst), .en_req(en_req), .cfg_load(cfg_load), .cfg_win(cfg_win),
        .cfg_warn(cfg_warn), .kick_valid(kick_valid), .kick_key(kick_key),
        .irq_clr(irq_clr), .cause_clr(cause_clr), .wdt_mr(mr_b), .wdt_to(to_b),
        .wdt_load(wdt_load_b), .wdt_en(wdt_en_b), .irq_warn(irq_b),
        .sys_rst_req(srst_b), .rst_cause(cause_b), .running(running_b)
    );

    // Watchdog model: loads while disabled, counts down to 0 while enabled.
    always @(posedge clk) begin
        if (!wdt_en_a) mr_a <= wdt_load_a;
        else if (mr_a != 32'd0) mr_a <= mr_a - 32'd1;
        if (!wdt_en_b) mr_b <= wdt_load_b;
        else if (mr_b != 32'd0) mr_b <= mr_b - 32'd1;
    end
    assign to_a = wdt_en_a && (mr_a == 32'd0);
    assign to_b = wdt_en_b && (mr_b == 32'd0);

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1; en_req = 1'b0; kick_valid = 1'b0; kick_key = 32'd0;
        irq_clr = 1'b0; cause_clr = 1'b0;
        tick(); tick();
        rst = 1'b0;
        tick();
    endtask

    // Arms with the given config and returns on the first RUN cycle.
    task automatic arm(input logic [31:0] ld, input logic [31:0] win, input logic [31:0] warn);
        logic ok;
        ok = 1'b0;
        cfg_load = ld; cfg_win = win; cfg_warn = warn; en_req = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (running_a) begin
                ok = 1'b1;
                break;
            end
        end
        vecs++;
        if (!ok) begin errs++; $display("FAIL arm_timeout: running=%0b required 1", running_a); end
    endtask

    task automatic test_reset();
        do_reset();
        vecs++; if (wdt_load_a !== 32'd0) begin errs++; $display("FAIL rst_load: got %0h req 0", wdt_load_a); end
        vecs++; if (wdt_en_a !== 1'b0) begin errs++; $display("FAIL rst_en: got %0b req 0", wdt_en_a); end
        vecs++; if (irq_a !== 1'b0) begin errs++; $display("FAIL rst_irq: got %0b req 0", irq_a); end
        vecs++; if (srst_a !== 1'b0) begin errs++; $display("FAIL rst_srst: got %0b req 0", srst_a); end
        vecs++; if (cause_a !== 2'b00) begin errs++; $display("FAIL rst_cause: got %0b req 00", cause_a); end
        vecs++; if (running_a !== 1'b0) begin errs++; $display("FAIL rst_running: got %0b req 0", running_a); end
        // Bad kick in IDLE is ignored
        kick_valid = 1'b1; kick_key = 32'd0;
        tick();
        kick_valid = 1'b0;
        tick();
        vecs++; if (srst_a !== 1'b0) begin errs++; $display("FAIL idle_kick_srst: got %0b req 0", srst_a); end
        vecs++; if (cause_a !== 2'b00) begin errs++; $display("FAIL idle_kick_cause: got %0b req 00", cause_a); end
        // Zero reload clamps to 1
        arm(32'd0, 32'd5, 32'd0);
        vecs++; if (wdt_load_a !== 32'd1) begin errs++; $display("FAIL load_clamp: got %0h req 1", wdt_load_a); end
        $display("test_reset done");
    endtask

    task automatic test_timeout();
        int n;
        int w;
        do_reset();
        arm(32'd10, 32'd10, 32'd0);
        vecs++; if (wdt_en_a !== 1'b1) begin errs++; $display("FAIL to_wdt_en: got %0b req 1", wdt_en_a); end
        vecs++; if (wdt_load_a !== 32'd10) begin errs++; $display("FAIL to_load: got %0d req 10", wdt_load_a); end
        n = 0;
        while (!srst_a && n < 40) begin tick(); n++; end
        vecs++; if (n != 11) begin errs++; $display("FAIL to_latency: got %0d req 11", n); end
        vecs++; if (cause_a !== 2'b01) begin errs++; $display("FAIL to_cause: got %0b req 01", cause_a); end
        w = 0;
        while (srst_a && w < 40) begin tick(); w++; end
        vecs++; if (w != 16) begin errs++; $display("FAIL to_pulse_width: got %0d req 16", w); end
        vecs++; if (running_a !== 1'b0) begin errs++; $display("FAIL to_idle: running=%0b req 0", running_a); end
        tick(); tick();
        vecs++; if (running_a !== 1'b1) begin errs++; $display("FAIL to_rearm: running=%0b req 1", running_a); end
        vecs++; if (cause_a !== 2'b01) begin errs++; $display("FAIL to_cause_hold: got %0b req 01", cause_a); end
        cause_clr = 1'b1;
        tick();
        cause_clr = 1'b0;
        vecs++; if (cause_a !== 2'b00) begin errs++; $display("FAIL cause_clr: got %0b req 00", cause_a); end
        $display("test_timeout done latency=%0d width=%0d", n, w);
    endtask

    task automatic test_window();
        do_reset();
        arm(32'd100, 32'd20, 32'd0);
        repeat (50) tick();
        kick_valid = 1'b1; kick_key = TB_KEY;
        tick();
        kick_valid = 1'b0;
        vecs++; if (srst_a !== 1'b1) begin errs++; $display("FAIL early_srst: got %0b req 1", srst_a); end
        vecs++; if (cause_a !== 2'b11) begin errs++; $display("FAIL early_cause: got %0b req 11", cause_a); end
        do_reset();
        arm(32'd100, 32'd20, 32'd0);
        repeat (85) tick();
        kick_valid = 1'b1; kick_key = TB_KEY;
        tick();
        vecs++; if (running_a !== 1'b1 || wdt_en_a !== 1'b0) begin
            errs++; $display("FAIL kick_state: running=%0b en=%0b req 1/0", running_a, wdt_en_a);
        end
        // Bad-key kick during KICK is ignored
        kick_key = 32'd0;
        tick();
        kick_valid = 1'b0;
        vecs++; if (wdt_en_a !== 1'b1) begin errs++; $display("FAIL kick_back_run: en=%0b req 1", wdt_en_a); end
        vecs++; if (mr_a !== 32'd100) begin errs++; $display("FAIL kick_reload: mr=%0d req 100", mr_a); end
        vecs++; if (srst_a !== 1'b0) begin errs++; $display("FAIL kick_no_srst: got %0b req 0", srst_a); end
        vecs++; if (cause_a !== 2'b00) begin errs++; $display("FAIL kick_no_cause: got %0b req 00", cause_a); end
        $display("test_window done");
    endtask

    task automatic test_bad_key();
        do_reset();
        arm(32'd100, 32'd100, 32'd0);
        repeat (3) tick();
        kick_valid = 1'b1; kick_key = 32'd0;
        tick();
        kick_valid = 1'b0;
        vecs++; if (srst_a !== 1'b1) begin errs++; $display("FAIL badkey_srst: got %0b req 1", srst_a); end
        vecs++; if (cause_a !== 2'b10) begin errs++; $display("FAIL badkey_cause: got %0b req 10", cause_a); end
        $display("test_bad_key done");
    endtask

    task automatic test_warn();
        do_reset();
        arm(32'd20, 32'd20, 32'd5);
        repeat (15) tick();
        vecs++; if (irq_a !== 1'b0) begin errs++; $display("FAIL warn_not_yet: got %0b req 0", irq_a); end
        tick();
        vecs++; if (irq_a !== 1'b1) begin errs++; $display("FAIL warn_set: got %0b req 1", irq_a); end
        kick_valid = 1'b1; kick_key = TB_KEY;
        tick();
        kick_valid = 1'b0;
        vecs++; if (irq_a !== 1'b1) begin errs++; $display("FAIL warn_across_kick: got %0b req 1", irq_a); end
        tick();
        repeat (15) tick();
        irq_clr = 1'b1;
        tick();
        irq_clr = 1'b0;
        vecs++; if (irq_a !== 1'b1) begin errs++; $display("FAIL warn_set_wins: got %0b req 1", irq_a); end
        irq_clr = 1'b1;
        tick();
        irq_clr = 1'b0;
        vecs++; if (irq_a !== 1'b0) begin errs++; $display("FAIL warn_clr: got %0b req 0", irq_a); end
        $display("test_warn done");
    endtask

    task automatic test_lock();
        do_reset();
        arm(32'd100, 32'd100, 32'd0);
        repeat (3) tick();
        en_req = 1'b0;
        repeat (2) tick();
        vecs++; if (running_a !== 1'b1 || wdt_en_a !== 1'b1) begin
            errs++; $display("FAIL lock1_hold: running=%0b en=%0b req 1/1", running_a, wdt_en_a);
        end
        vecs++; if (running_b !== 1'b0 || wdt_en_b !== 1'b0) begin
            errs++; $display("FAIL lock0_idle: running=%0b en=%0b req 0/0", running_b, wdt_en_b);
        end
        $display("test_lock done");
    endtask

    task automatic test_to_priority();
        do_reset();
        arm(32'd10, 32'd10, 32'd0);
        repeat (10) tick();
        kick_valid = 1'b1; kick_key = TB_KEY; cause_clr = 1'b1;
        tick();
        kick_valid = 1'b0; cause_clr = 1'b0;
        vecs++; if (srst_a !== 1'b1) begin errs++; $display("FAIL prio_srst: got %0b req 1", srst_a); end
        vecs++; if (cause_a !== 2'b01) begin errs++; $display("FAIL prio_cause: got %0b req 01", cause_a); end
        repeat (3) tick();
        vecs++; if (srst_a !== 1'b1) begin errs++; $display("FAIL mid_bite_srst: got %0b req 1", srst_a); end
        rst = 1'b1;
        tick();
        vecs++; if (srst_a !== 1'b0) begin errs++; $display("FAIL bite_rst_srst: got %0b req 0", srst_a); end
        vecs++; if (cause_a !== 2'b00 || wdt_en_a !== 1'b0 || running_a !== 1'b0 ||
                     irq_a !== 1'b0 || wdt_load_a !== 32'd0) begin
            errs++; $display("FAIL bite_rst_outputs: cause=%0b en=%0b run=%0b irq=%0b load=%0h req all 0",
                             cause_a, wdt_en_a, running_a, irq_a, wdt_load_a);
        end
        rst = 1'b0;
        $display("test_to_priority done");
    endtask

    initial begin
        rst = 1'b1; en_req = 1'b0; cfg_load = 32'd0; cfg_win = 32'd0; cfg_warn = 32'd0;
        kick_valid = 1'b0; kick_key = 32'd0; irq_clr = 1'b0; cause_clr = 1'b0;
        test_reset();
        test_timeout();
        test_window();
        test_bad_key();
        test_warn();
        test_lock();
        test_to_priority();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
